gpio_burst_ctrl: RTL and testbench
==================================

GPIO_BURST_CTRL -- requirements
Module: gpio_burst_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of beat counter and beat_cnt output.
REQ-002 Parameter DRAIN_CYC, default 4: cycles ready is held low after a burst ends, before irq.
REQ-003 Parameter TIMEOUT_CYC, default 255: burst watchdog limit in cycles (used only with REQ-026).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 beat_vld  in  1  beat strobe from GPIO agent.
REQ-007 addr_space  in  2  address space of current beat; bit1 = ADDR_SPACE_1, bit0 = ADDR_SPACE_0.
REQ-008 last  in  1  marks final beat of burst; qualified by beat_vld.
REQ-009 irq_ack  in  1  interrupt acknowledge.
REQ-010 ready  out  1  block accepts beats; drives agent READY input.
REQ-011 irq  out  1  burst-complete interrupt; drives agent IRQ input.
REQ-012 irq_space  out  2  address space latched on first beat of completed burst.
REQ-013 beat_cnt  out  CNT_W  beats accepted in completed burst.
REQ-014 err  out  1  sticky burst error (overflow, space change, timeout).

Function
REQ-015 Beat accepted iff beat_vld=1 and ready=1 at rising edge; beat_vld with ready=0 SHALL be ignored with no state change.
REQ-016 FSM states IDLE, BURST, DRAIN, IRQ; ready=1 in IDLE and BURST only, irq=1 in IRQ only.
REQ-017 IDLE: accepted beat latches addr_space into irq_space, sets count=1, clears err; -> DRAIN if last=1, else -> BURST.
REQ-018 BURST: each accepted beat increments count; accepted beat with last=1 -> DRAIN.
REQ-019 Count SHALL saturate at 2^CNT_W-1; an accepted beat at saturation sets err, count unchanged.
REQ-020 addr_space differing from latched irq_space on an accepted BURST beat sets err; beat counted, irq_space unchanged.
REQ-021 DRAIN: down-counter loaded with DRAIN_CYC on entry; -> IRQ when it reaches 0; DRAIN_CYC=0 SHALL pass through DRAIN in exactly one cycle.
REQ-022 Latency: last accepted at edge N -> irq=1 after edge N+DRAIN_CYC+1, ready=0 from after edge N.
REQ-023 IRQ: irq, irq_space, beat_cnt, err held stable; irq_ack=1 sampled -> IDLE, irq=0 and ready=1 after same edge.
REQ-024 irq_ack in IDLE, BURST, DRAIN SHALL be ignored; beat_cnt updates only on IRQ entry (holds previous result otherwise).

Reset
REQ-025 While rst_n=0 at an edge: state IDLE, ready=0, irq=0, irq_space=0, beat_cnt=0, err=0, counters 0; ready=1 after first edge with rst_n=1; reset mid-burst SHALL discard the burst with no irq.

Configuration
REQ-026 Macro GPIO_BURST_TIMEOUT_EN defined: cycle counter runs in BURST, cleared on every accepted beat; reaching TIMEOUT_CYC consecutive idle cycles sets err and forces -> DRAIN as if last were accepted.
REQ-027 Macro undefined: no watchdog logic; BURST waits indefinitely for last; TIMEOUT_CYC unused.

Verification
REQ-028 Reset release, then 3 beats addr_space=2'b01, last on 3rd, DRAIN_CYC=4 -> irq=1 five cycles after 3rd beat, beat_cnt=3, irq_space=01, err=0; irq_ack -> ready=1 next cycle.
REQ-029 Single beat with last=1 in IDLE, DRAIN_CYC=0 -> irq=1 after second edge, beat_cnt=1.
REQ-030 CNT_W=2, 5 beats then last -> beat_cnt=3, err=1.
REQ-031 Beats space 10,10,11(last) -> irq_space=10, beat_cnt=3, err=1; beat_vld pulses during DRAIN/IRQ not counted.
REQ-032 rst_n=0 for one cycle mid-burst -> all outputs 0, no irq, fresh burst counts from 1.
REQ-033 With GPIO_BURST_TIMEOUT_EN, TIMEOUT_CYC=10, 2 beats then silence -> err=1, irq=1 after 10+DRAIN_CYC+1 cycles, beat_cnt=2.

Source files
------------

// File: rtl/gpio_burst_ctrl.sv
// Burst collector for a GPIO agent: counts beats, drains, then raises a completion irq.
// Optional burst watchdog enabled by defining GPIO_BURST_TIMEOUT_EN.
module gpio_burst_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DRAIN_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_vld,
  input  logic [1:0]       addr_space,
  input  logic             last,
  input  logic             irq_ack,
  output logic             ready,
  output logic             irq,
  output logic [1:0]       irq_space,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             err
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, IRQ} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [DRAIN_W-1:0] drain, drain_nxt;
  logic [1:0]         irq_space_nxt;
  logic [CNT_W-1:0]   beat_cnt_nxt;
  logic               err_nxt;
  logic               accept;

`ifdef GPIO_BURST_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [TMO_W-1:0] tmo, tmo_nxt;
`endif

  assign accept = beat_vld & ready;

  // Next-state, counters and result capture
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    drain_nxt     = drain;
    irq_space_nxt = irq_space;
    beat_cnt_nxt  = beat_cnt;
    err_nxt       = err;
`ifdef GPIO_BURST_TIMEOUT_EN
    tmo_nxt       = tmo;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          irq_space_nxt = addr_space;
          count_nxt     = CNT_W'(1);
          err_nxt       = 1'b0;
`ifdef GPIO_BURST_TIMEOUT_EN
          tmo_nxt       = '0;
`endif
          if (last) begin
            state_nxt = DRAIN;
            drain_nxt = DRAIN_W'(DRAIN_CYC);
          end else begin
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        if (accept) begin
          if (count == CNT_MAX) err_nxt = 1'b1;
          else                  count_nxt = count + CNT_W'(1);
          if (addr_space != irq_space) err_nxt = 1'b1;
`ifdef GPIO_BURST_TIMEOUT_EN
          tmo_nxt = '0;
`endif
          if (last) begin
            state_nxt = DRAIN;
            drain_nxt = DRAIN_W'(DRAIN_CYC);
          end
        end
`ifdef GPIO_BURST_TIMEOUT_EN
        // Watchdog: close the burst after TIMEOUT_CYC consecutive beat-free cycles
        else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_nxt   = 1'b1;
          tmo_nxt   = '0;
          state_nxt = DRAIN;
          drain_nxt = DRAIN_W'(DRAIN_CYC);
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (drain == '0) begin
          state_nxt    = IRQ;
          beat_cnt_nxt = count;
        end else begin
          drain_nxt = drain - DRAIN_W'(1);
        end
      end
      IRQ: begin
        if (irq_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; ready/irq follow the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      drain     <= '0;
      irq_space <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      ready     <= 1'b0;
      irq       <= 1'b0;
`ifdef GPIO_BURST_TIMEOUT_EN
      tmo       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      drain     <= drain_nxt;
      irq_space <= irq_space_nxt;
      beat_cnt  <= beat_cnt_nxt;
      err       <= err_nxt;
      ready     <= (state_nxt == IDLE) || (state_nxt == BURST);
      irq       <= (state_nxt == IRQ);
`ifdef GPIO_BURST_TIMEOUT_EN
      tmo       <= tmo_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_gpio_burst_ctrl.sv
// Self-checking bench for gpio_burst_ctrl: vector table on the default instance plus
// directed sequences for drain bypass, counter saturation, mid-burst reset and watchdog.
module tb_gpio_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       beat_vld = 1'b0;
  logic [1:0] addr_space = 2'b00;
  logic       last = 1'b0;
  logic       irq_ack = 1'b0;

  always #5 clk = ~clk;

  logic       a_ready, a_irq, a_err;
  logic [1:0] a_space;
  logic [7:0] a_cnt;
  logic       b_ready, b_irq, b_err;
  logic [1:0] b_space;
  logic [7:0] b_cnt;
  logic       c_ready, c_irq, c_err;
  logic [1:0] c_space;
  logic [1:0] c_cnt;
  logic       d_ready, d_irq, d_err;
  logic [1:0] d_space;
  logic [7:0] d_cnt;

  gpio_burst_ctrl #(.CNT_W(8), .DRAIN_CYC(4), .TIMEOUT_CYC(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .beat_vld(beat_vld), .addr_space(addr_space), .last(last),
    .irq_ack(irq_ack), .ready(a_ready), .irq(a_irq), .irq_space(a_space), .beat_cnt(a_cnt),
    .err(a_err));

  gpio_burst_ctrl #(.CNT_W(8), .DRAIN_CYC(0), .TIMEOUT_CYC(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .beat_vld(beat_vld), .addr_space(addr_space), .last(last),
    .irq_ack(irq_ack), .ready(b_ready), .irq(b_irq), .irq_space(b_space), .beat_cnt(b_cnt),
    .err(b_err));

  gpio_burst_ctrl #(.CNT_W(2), .DRAIN_CYC(4), .TIMEOUT_CYC(255)) dut_c (
    .clk(clk), .rst_n(rst_n), .beat_vld(beat_vld), .addr_space(addr_space), .last(last),
    .irq_ack(irq_ack), .ready(c_ready), .irq(c_irq), .irq_space(c_space), .beat_cnt(c_cnt),
    .err(c_err));

  gpio_burst_ctrl #(.CNT_W(8), .DRAIN_CYC(4), .TIMEOUT_CYC(10)) dut_d (
    .clk(clk), .rst_n(rst_n), .beat_vld(beat_vld), .addr_space(addr_space), .last(last),
    .irq_ack(irq_ack), .ready(d_ready), .irq(d_irq), .irq_space(d_space), .beat_cnt(d_cnt),
    .err(d_err));

  typedef struct {
    logic       vld;
    logic [1:0] sp;
    logic       lst;
    logic       ack;
    logic       rdy;
    logic       irq;
    logic [1:0] isp;
    logic [7:0] cnt;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [1:0] sp, input logic lst, input logic ack,
                     input logic rdy, input logic irq_e, input logic [1:0] isp,
                     input logic [7:0] cnt, input logic err_e);
    vec_t v;
    v.vld = vld; v.sp = sp; v.lst = lst; v.ack = ack;
    v.rdy = rdy; v.irq = irq_e; v.isp = isp; v.cnt = cnt; v.err = err_e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic vld, input logic [1:0] sp, input logic lst, input logic ack);
    beat_vld = vld; addr_space = sp; last = lst; irq_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  function automatic logic irq_of(input int sel);
    case (sel)
      0:       return a_irq;
      1:       return b_irq;
      2:       return c_irq;
      default: return d_irq;
    endcase
  endfunction

  // Idle the inputs and count edges until the selected instance raises irq (-1 if it never does)
  task automatic wait_irq(input int sel, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      if (cycles < 0 && irq_of(sel)) cycles = i;
      if (cycles >= 0) break;
    end
  endtask

  initial begin
    int  cyc;
    logic seen;

    //  vld sp     lst ack | rdy irq isp    cnt err
    add(0, 2'b00, 0, 0,    1, 0, 2'b00, 0, 0); // first edge after reset release
    add(1, 2'b01, 0, 0,    1, 0, 2'b01, 0, 0);
    add(1, 2'b01, 0, 0,    1, 0, 2'b01, 0, 0);
    add(1, 2'b01, 1, 0,    0, 0, 2'b01, 0, 0); // last: edge N
    add(0, 2'b00, 0, 1,    0, 0, 2'b01, 0, 0); // ack in DRAIN ignored
    add(1, 2'b11, 0, 0,    0, 0, 2'b01, 0, 0); // beat in DRAIN ignored
    add(0, 2'b00, 0, 0,    0, 0, 2'b01, 0, 0);
    add(0, 2'b00, 0, 0,    0, 0, 2'b01, 0, 0); // edge N+4
    add(0, 2'b00, 0, 0,    0, 1, 2'b01, 3, 0); // edge N+5: irq
    add(1, 2'b10, 0, 0,    0, 1, 2'b01, 3, 0); // beat in IRQ ignored
    add(0, 2'b00, 0, 1,    1, 0, 2'b01, 3, 0); // ack -> IDLE
    add(1, 2'b10, 0, 0,    1, 0, 2'b10, 3, 0); // new burst, beat_cnt holds
    add(1, 2'b10, 0, 0,    1, 0, 2'b10, 3, 0);
    add(1, 2'b11, 1, 0,    0, 0, 2'b10, 3, 1); // space change -> err
    add(1, 2'b10, 0, 0,    0, 0, 2'b10, 3, 1);
    add(1, 2'b10, 1, 0,    0, 0, 2'b10, 3, 1);
    add(1, 2'b10, 0, 0,    0, 0, 2'b10, 3, 1);
    add(1, 2'b10, 0, 0,    0, 0, 2'b10, 3, 1);
    add(0, 2'b00, 0, 0,    0, 1, 2'b10, 3, 1); // drain pulses not counted
    add(1, 2'b10, 0, 0,    0, 1, 2'b10, 3, 1);
    add(0, 2'b00, 0, 1,    1, 0, 2'b10, 3, 1); // err sticky into IDLE
    add(0, 2'b00, 0, 1,    1, 0, 2'b10, 3, 1); // ack in IDLE ignored
    add(1, 2'b00, 1, 0,    0, 0, 2'b00, 3, 0); // single-beat burst clears err
    add(0, 2'b00, 0, 0,    0, 0, 2'b00, 3, 0);
    add(0, 2'b00, 0, 0,    0, 0, 2'b00, 3, 0);
    add(0, 2'b00, 0, 0,    0, 0, 2'b00, 3, 0);
    add(0, 2'b00, 0, 0,    0, 0, 2'b00, 3, 0);
    add(0, 2'b00, 0, 0,    0, 1, 2'b00, 1, 0);
    add(0, 2'b00, 0, 1,    1, 0, 2'b00, 1, 0);
    add(1, 2'b01, 0, 0,    1, 0, 2'b01, 1, 0);
    add(0, 2'b00, 0, 1,    1, 0, 2'b01, 1, 0); // ack in BURST ignored
    add(1, 2'b01, 1, 0,    0, 0, 2'b01, 1, 0);

    // Reset values while rst_n is low
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b1, 1'b1);
    chk("rst.ready", 32'(a_ready), 32'd0);
    chk("rst.irq", 32'(a_irq), 32'd0);
    chk("rst.space", 32'(a_space), 32'd0);
    chk("rst.cnt", 32'(a_cnt), 32'd0);
    chk("rst.err", 32'(a_err), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].sp, vecs[i].lst, vecs[i].ack);
      chk($sformatf("v%0d.ready", i), 32'(a_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.irq", i), 32'(a_irq), 32'(vecs[i].irq));
      chk($sformatf("v%0d.space", i), 32'(a_space), 32'(vecs[i].isp));
      chk($sformatf("v%0d.cnt", i), 32'(a_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d.err", i), 32'(a_err), 32'(vecs[i].err));
    end

    // Zero-length drain: irq one edge after the single beat
    do_reset();
    drive(1'b1, 2'b10, 1'b1, 1'b0);
    chk("nodrain.ready", 32'(b_ready), 32'd0);
    chk("nodrain.irq_early", 32'(b_irq), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("nodrain.irq", 32'(b_irq), 32'd1);
    chk("nodrain.cnt", 32'(b_cnt), 32'd1);
    chk("nodrain.space", 32'(b_space), 32'd2);
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    chk("nodrain.ack_ready", 32'(b_ready), 32'd1);

    // Two-bit counter saturates at 3 and flags err
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b1, 1'b0);
    wait_irq(2, 20, cyc);
    chk("sat.latency", 32'(cyc), 32'd5);
    chk("sat.cnt", 32'(c_cnt), 32'd3);
    chk("sat.err", 32'(c_err), 32'd1);

    // One-cycle reset mid-burst discards the burst
    do_reset();
    drive(1'b1, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 1'b0);
    chk("midrst.pre_space", 32'(a_space), 32'd3);
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("midrst.ready", 32'(a_ready), 32'd0);
    chk("midrst.irq", 32'(a_irq), 32'd0);
    chk("midrst.space", 32'(a_space), 32'd0);
    chk("midrst.cnt", 32'(a_cnt), 32'd0);
    chk("midrst.err", 32'(a_err), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      seen = seen | a_irq;
    end
    chk("midrst.no_irq", 32'(seen), 32'd0);
    chk("midrst.ready_back", 32'(a_ready), 32'd1);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b1, 1'b0);
    wait_irq(0, 20, cyc);
    chk("midrst.fresh_latency", 32'(cyc), 32'd5);
    chk("midrst.fresh_cnt", 32'(a_cnt), 32'd2);
    chk("midrst.fresh_err", 32'(a_err), 32'd0);

`ifdef GPIO_BURST_TIMEOUT_EN
    // Watchdog closes a stalled burst after 10 idle cycles
    do_reset();
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    wait_irq(3, 40, cyc);
    chk("tmo.latency", 32'(cyc), 32'd15);
    chk("tmo.err", 32'(d_err), 32'd1);
    chk("tmo.cnt", 32'(d_cnt), 32'd2);
`else
    // Without the watchdog a stalled burst waits indefinitely
    do_reset();
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    wait_irq(3, 40, cyc);
    chk("notmo.no_irq", 32'(cyc), 32'hFFFF_FFFF);
    chk("notmo.ready", 32'(d_ready), 32'd1);
    chk("notmo.err", 32'(d_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
